// File: rtl/uart_cmd_decoder_pkg.sv
// Shared opcodes, FSM encoding and ctrl field layout for the UART command decoder.
// Opcodes sit in the high nibble range so small argument bytes never alias an opcode.
package uart_cmd_decoder_pkg;

  localparam logic [7:0] CMD_DATA   = 8'hD0;
  localparam logic [7:0] CMD_CTRL   = 8'hC0;
  localparam logic [7:0] CMD_FREQ   = 8'hF0;
  localparam logic [7:0] CMD_PERIOD = 8'hB0;
  localparam logic [7:0] CMD_REPEAT = 8'hA0;
  localparam logic [7:0] CMD_GLOBAL = 8'h90;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_MODE_LSB = 1;
  localparam int CTRL_MODE_MSB = 2;
  localparam int CTRL_IDLE_BIT = 3;

  localparam logic [1:0] MODE_ONE_SHOT = 2'b00;
  localparam logic [1:0] MODE_CONTINUE = 2'b01;
  localparam logic [1:0] MODE_REPEAT   = 2'b10;

  typedef enum logic [2:0] {
    S_OPCODE  = 3'd0,
    S_CH      = 3'd1,
    S_AMOUNT  = 3'd2,
    S_PAYLOAD = 3'd3,
    S_ARG     = 3'd4
  } state_e;

  // State entered after an opcode byte; S_OPCODE means the opcode is unknown.
  function automatic state_e opcode_next(input logic [7:0] op);
    case (op)
      CMD_DATA, CMD_REPEAT, CMD_CTRL: return S_CH;
      CMD_FREQ:                       return S_AMOUNT;
      CMD_PERIOD, CMD_GLOBAL:         return S_ARG;
      default:                        return S_OPCODE;
    endcase
  endfunction

endpackage

// File: rtl/uart_cmd_decoder_cmd_byte_shifter.sv
// Pattern accumulator: clear, write byte at index k into bits [8k+7:8k]; unwritten bytes stay zero.
// acc_nxt_o is the combinational next value so the final byte can be committed the cycle after its tick.
module uart_cmd_decoder_cmd_byte_shifter #(
  parameter int DATA_BIT = 64
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                clr_i,
  input  logic                wr_i,
  input  logic [7:0]          idx_i,
  input  logic [7:0]          byte_i,
  output logic [DATA_BIT-1:0] acc_nxt_o
);

  localparam int NB = DATA_BIT / 8;

  logic [DATA_BIT-1:0] acc_q, acc_d;

  // Indices beyond the pattern width are silently dropped.
  always_comb begin
    acc_d = acc_q;
    if (clr_i) begin
      acc_d = '0;
    end else if (wr_i) begin
      for (int k = 0; k < NB; k++) begin
        if (int'(idx_i) == k) acc_d[8*k +: 8] = byte_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) acc_q <= '0;
    else         acc_q <= acc_d;
  end

  assign acc_nxt_o = acc_d;

endmodule

// File: rtl/uart_cmd_decoder.sv
// UART byte-stream command parser; strobes and fields register the cycle after the final byte tick.
// Optional CMD_TIMEOUT_EN aborts a stalled command after TIMEOUT_CYCLES idle clocks.
module uart_cmd_decoder
  import uart_cmd_decoder_pkg::*;
#(
  parameter int DATA_BIT       = 64,
  parameter int OUTPUT_NUM     = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [7:0]                    data_i,
  input  logic                          rx_done_tick_i,
  output logic [$clog2(OUTPUT_NUM)-1:0] ch_o,
  output logic [DATA_BIT-1:0]           pattern_o,
  output logic [3:0]                    ctrl_o,
  output logic [7:0]                    slow_period_o,
  output logic [7:0]                    fast_period_o,
  output logic [7:0]                    repeat_o,
  output logic                          stop_o,
  output logic                          data_we_o,
  output logic                          ctrl_we_o,
  output logic                          freq_we_o,
  output logic                          period_we_o,
  output logic                          repeat_we_o,
  output logic                          global_we_o,
  output logic                          err_o,
  output logic                          busy_o
);

  localparam int NB  = DATA_BIT / 8;
  localparam int CHW = $clog2(OUTPUT_NUM);

  state_e              state_q;
  logic [7:0]          opc_q, amt_q, cnt_q, arg0_q;
  logic [CHW-1:0]      ch_q;
  logic                arg_idx_q, bad_q;
  logic [CHW-1:0]      ch_out_q;
  logic [DATA_BIT-1:0] pattern_q;
  logic [3:0]          ctrl_q;
  logic [7:0]          slow_q, fast_q, repeat_q;
  logic                stop_q;
  logic                data_we_q, ctrl_we_q, freq_we_q, period_we_q, repeat_we_q, global_we_q, err_q;

  logic                sh_clr, sh_wr, tmo_hit;
  logic [DATA_BIT-1:0] acc_nxt;

  assign sh_clr = rx_done_tick_i && (state_q == S_AMOUNT);
  assign sh_wr  = rx_done_tick_i && (state_q == S_PAYLOAD);

  uart_cmd_decoder_cmd_byte_shifter #(.DATA_BIT(DATA_BIT)) u_shifter (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .clr_i     (sh_clr),
    .wr_i      (sh_wr),
    .idx_i     (cnt_q),
    .byte_i    (data_i),
    .acc_nxt_o (acc_nxt)
  );

`ifdef CMD_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)                                        tmo_q <= '0;
    else if (rx_done_tick_i || (state_q == S_OPCODE)) tmo_q <= '0;
    else                                                tmo_q <= tmo_q + 1'b1;
  end

  // A tick in the timeout cycle takes priority and the byte is processed.
  assign tmo_hit = (state_q != S_OPCODE) && !rx_done_tick_i && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_OPCODE;
      opc_q       <= '0;
      amt_q       <= '0;
      cnt_q       <= '0;
      arg0_q      <= '0;
      ch_q        <= '0;
      arg_idx_q   <= 1'b0;
      bad_q       <= 1'b0;
      ch_out_q    <= '0;
      pattern_q   <= '0;
      ctrl_q      <= '0;
      slow_q      <= '0;
      fast_q      <= '0;
      repeat_q    <= '0;
      stop_q      <= 1'b0;
      data_we_q   <= 1'b0;
      ctrl_we_q   <= 1'b0;
      freq_we_q   <= 1'b0;
      period_we_q <= 1'b0;
      repeat_we_q <= 1'b0;
      global_we_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      data_we_q   <= 1'b0;
      ctrl_we_q   <= 1'b0;
      freq_we_q   <= 1'b0;
      period_we_q <= 1'b0;
      repeat_we_q <= 1'b0;
      global_we_q <= 1'b0;
      err_q       <= 1'b0;
      if (rx_done_tick_i) begin
        case (state_q)
          S_OPCODE: begin
            opc_q     <= data_i;
            bad_q     <= 1'b0;
            arg_idx_q <= 1'b0;
            state_q   <= opcode_next(data_i);
            if (opcode_next(data_i) == S_OPCODE) err_q <= 1'b1;
          end
          S_CH: begin
            ch_q <= data_i[CHW-1:0];
            if (int'(data_i) >= OUTPUT_NUM) bad_q <= 1'b1;
            state_q <= (opc_q == CMD_DATA) ? S_AMOUNT : S_ARG;
          end
          S_AMOUNT: begin
            amt_q <= data_i;
            cnt_q <= '0;
            if (int'(data_i) > NB - 1) bad_q <= 1'b1;
            state_q <= S_PAYLOAD;
          end
          S_PAYLOAD: begin
            if (cnt_q == amt_q) begin
              state_q <= S_OPCODE;
              if (bad_q) begin
                err_q <= 1'b1;
              end else begin
                pattern_q <= acc_nxt;
                if (opc_q == CMD_DATA) begin
                  ch_out_q  <= ch_q;
                  data_we_q <= 1'b1;
                end else begin
                  freq_we_q <= 1'b1;
                end
              end
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end
          S_ARG: begin
            if ((opc_q == CMD_PERIOD) && !arg_idx_q) begin
              arg0_q    <= data_i;
              arg_idx_q <= 1'b1;
            end else begin
              state_q <= S_OPCODE;
              if (bad_q) begin
                err_q <= 1'b1;
              end else begin
                case (opc_q)
                  CMD_PERIOD: begin
                    slow_q      <= arg0_q;
                    fast_q      <= data_i;
                    period_we_q <= 1'b1;
                  end
                  CMD_CTRL: begin
                    ch_out_q  <= ch_q;
                    ctrl_q    <= data_i[3:0];
                    ctrl_we_q <= 1'b1;
                  end
                  CMD_REPEAT: begin
                    ch_out_q    <= ch_q;
                    repeat_q    <= data_i;
                    repeat_we_q <= 1'b1;
                  end
                  default: begin
                    stop_q      <= data_i[0];
                    global_we_q <= 1'b1;
                  end
                endcase
              end
            end
          end
          default: state_q <= S_OPCODE;
        endcase
      end else if (tmo_hit) begin
        state_q <= S_OPCODE;
        err_q   <= 1'b1;
      end
    end
  end

  assign ch_o          = ch_out_q;
  assign pattern_o     = pattern_q;
  assign ctrl_o        = ctrl_q;
  assign slow_period_o = slow_q;
  assign fast_period_o = fast_q;
  assign repeat_o      = repeat_q;
  assign stop_o        = stop_q;
  assign data_we_o     = data_we_q;
  assign ctrl_we_o     = ctrl_we_q;
  assign freq_we_o     = freq_we_q;
  assign period_we_o   = period_we_q;
  assign repeat_we_o   = repeat_we_q;
  assign global_we_o   = global_we_q;
  assign err_o         = err_q;
  assign busy_o        = (state_q != S_OPCODE);

endmodule

// File: tb/tb_uart_cmd_decoder.sv
// Directed table-driven bench for uart_cmd_decoder plus hand sequences for back-to-back, reset and timeout.
module tb_uart_cmd_decoder;
  import uart_cmd_decoder_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic [7:0]  data_i = '0;
  logic        rx_done_tick_i = 1'b0;
  logic [3:0]  ch_o;
  logic [63:0] pattern_o;
  logic [3:0]  ctrl_o;
  logic [7:0]  slow_period_o, fast_period_o, repeat_o;
  logic        stop_o, data_we_o, ctrl_we_o, freq_we_o, period_we_o, repeat_we_o, global_we_o;
  logic        err_o, busy_o;

  uart_cmd_decoder #(.DATA_BIT(64), .OUTPUT_NUM(16), .TIMEOUT_CYCLES(100)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .data_i(data_i), .rx_done_tick_i(rx_done_tick_i),
    .ch_o(ch_o), .pattern_o(pattern_o), .ctrl_o(ctrl_o),
    .slow_period_o(slow_period_o), .fast_period_o(fast_period_o), .repeat_o(repeat_o),
    .stop_o(stop_o), .data_we_o(data_we_o), .ctrl_we_o(ctrl_we_o), .freq_we_o(freq_we_o),
    .period_we_o(period_we_o), .repeat_we_o(repeat_we_o), .global_we_o(global_we_o),
    .err_o(err_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  localparam logic [5:0] W_DATA = 6'b100000, W_CTRL = 6'b010000, W_FREQ = 6'b001000,
                         W_PER  = 6'b000100, W_REP  = 6'b000010, W_GLB  = 6'b000001;

  typedef struct {
    logic [95:0] bs;
    int          n;
    logic [5:0]  we;
    logic        err;
    logic [3:0]  ch;
    logic [63:0] pat;
    logic [3:0]  ctrl;
    logic [7:0]  slow, fast, rpt;
    logic        stop;
  } vec_t;

  localparam int NV = 12;
  vec_t vt [NV];

  int total = 0;
  int bad = 0;
  int pulses;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic [5:0] we_bus();
    return {data_we_o, ctrl_we_o, freq_we_o, period_we_o, repeat_we_o, global_we_o};
  endfunction

  task automatic observe();
    pulses += $countones(we_bus()) + int'(err_o);
  endtask

  task automatic send(input logic [7:0] b);
    data_i = b;
    rx_done_tick_i = 1'b1;
    @(negedge clk_i);
    rx_done_tick_i = 1'b0;
  endtask

  initial begin
    logic [5:0] cwe;
    logic       cerr;
    logic [63:0] pat_exp;

    vt[0]  = '{bs: {8'hF0, 8'h02, 8'h55, 8'h55, 8'h55}, n: 5, we: W_FREQ, err: 0,
               ch: 0, pat: 64'h0000_0000_0055_5555, ctrl: 0, slow: 0, fast: 0, rpt: 0, stop: 0};
    vt[1]  = '{bs: {8'hB0, 8'h14, 8'h05}, n: 3, we: W_PER, err: 0,
               ch: 0, pat: 64'h0000_0000_0055_5555, ctrl: 0, slow: 8'h14, fast: 8'h05, rpt: 0, stop: 0};
    vt[2]  = '{bs: {8'hA0, 8'h0F, 8'h03}, n: 3, we: W_REP, err: 0,
               ch: 4'hF, pat: 64'h0000_0000_0055_5555, ctrl: 0, slow: 8'h14, fast: 8'h05, rpt: 8'h03, stop: 0};
    vt[3]  = '{bs: {8'hD0, 8'h00, 8'h07, 8'h55, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h01, 8'h55}, n: 11,
               we: W_DATA, err: 0, ch: 0, pat: 64'h5501_0101_0101_0155, ctrl: 0, slow: 8'h14, fast: 8'h05,
               rpt: 8'h03, stop: 0};
    vt[4]  = '{bs: {8'hC0, 8'h00, 8'h05}, n: 3, we: W_CTRL, err: 0,
               ch: 0, pat: 64'h5501_0101_0101_0155, ctrl: {1'b0, MODE_REPEAT, 1'b1}, slow: 8'h14, fast: 8'h05,
               rpt: 8'h03, stop: 0};
    vt[5]  = '{bs: {8'hEE}, n: 1, we: 0, err: 1,
               ch: 0, pat: 64'h5501_0101_0101_0155, ctrl: 4'h5, slow: 8'h14, fast: 8'h05, rpt: 8'h03, stop: 0};
    vt[6]  = '{bs: {8'hD0, 8'h10, 8'h00, 8'hAA}, n: 4, we: 0, err: 1,
               ch: 0, pat: 64'h5501_0101_0101_0155, ctrl: 4'h5, slow: 8'h14, fast: 8'h05, rpt: 8'h03, stop: 0};
    vt[7]  = '{bs: {8'hF0, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h99}, n: 11,
               we: 0, err: 1, ch: 0, pat: 64'h5501_0101_0101_0155, ctrl: 4'h5, slow: 8'h14, fast: 8'h05,
               rpt: 8'h03, stop: 0};
    vt[8]  = '{bs: {8'hF0, 8'h00, 8'h7E}, n: 3, we: W_FREQ, err: 0,
               ch: 0, pat: 64'h7E, ctrl: 4'h5, slow: 8'h14, fast: 8'h05, rpt: 8'h03, stop: 0};
    vt[9]  = '{bs: {8'hC0, 8'h10, 8'h01}, n: 3, we: 0, err: 1,
               ch: 0, pat: 64'h7E, ctrl: 4'h5, slow: 8'h14, fast: 8'h05, rpt: 8'h03, stop: 0};
    vt[10] = '{bs: {8'hB0, 8'hFF, 8'h01}, n: 3, we: W_PER, err: 0,
               ch: 0, pat: 64'h7E, ctrl: 4'h5, slow: 8'hFF, fast: 8'h01, rpt: 8'h03, stop: 0};
    vt[11] = '{bs: {8'hA0, 8'h03, 8'hFF}, n: 3, we: W_REP, err: 0,
               ch: 4'h3, pat: 64'h7E, ctrl: 4'h5, slow: 8'hFF, fast: 8'h01, rpt: 8'hFF, stop: 0};

    // Reset state
    repeat (2) @(negedge clk_i);
    chk("rst_fields", {ch_o, ctrl_o, slow_period_o, fast_period_o, repeat_o, stop_o}, '0);
    chk("rst_pattern", pattern_o, '0);
    chk("rst_strobes", {we_bus(), err_o, busy_o}, '0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    for (int v = 0; v < NV; v++) begin
      pulses = 0;
      cwe = '0;
      cerr = 1'b0;
      for (int i = 0; i < vt[v].n; i++) begin
        for (int g = 0; g < (i % 3); g++) begin
          @(negedge clk_i);
          observe();
        end
        send(vt[v].bs[8*(vt[v].n-1-i) +: 8]);
        observe();
        if (i == vt[v].n - 1) begin
          cwe = we_bus();
          cerr = err_o;
        end
      end
      @(negedge clk_i);
      observe();
      chk($sformatf("v%0d_we", v), cwe, vt[v].we);
      chk($sformatf("v%0d_err", v), cerr, vt[v].err);
      chk($sformatf("v%0d_pulses", v), pulses, $countones(vt[v].we) + int'(vt[v].err));
      chk($sformatf("v%0d_busy", v), busy_o, 0);
      chk($sformatf("v%0d_pat", v), pattern_o, vt[v].pat);
      chk($sformatf("v%0d_fields", v), {ch_o, ctrl_o, slow_period_o, fast_period_o, repeat_o, stop_o},
          {vt[v].ch, vt[v].ctrl, vt[v].slow, vt[v].fast, vt[v].rpt, vt[v].stop});
    end

    // Back-to-back: second opcode arrives in the commit cycle of the first command.
    send(CMD_GLOBAL);
    chk("b2b_busy_mid", busy_o, 1);
    send(8'h00);
    chk("b2b_first_we", we_bus(), W_GLB);
    chk("b2b_first_stop", stop_o, 0);
    send(CMD_GLOBAL);
    chk("b2b_gap_we", we_bus(), 0);
    chk("b2b_busy", busy_o, 1);
    send(8'h01);
    chk("b2b_second_we", we_bus(), W_GLB);
    chk("b2b_second_stop", stop_o, 1);
    @(negedge clk_i);
    chk("b2b_after_we", we_bus(), 0);

    // Mid-command reset clears everything with no strobe.
    send(CMD_DATA);
    send(8'h01);
    chk("mid_busy", busy_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_busy", busy_o, 0);
    chk("mid_rst_out", {we_bus(), err_o, stop_o, ch_o, ctrl_o}, '0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    pulses = 0;
    repeat (3) begin
      @(negedge clk_i);
      observe();
    end
    chk("mid_rst_quiet", pulses, 0);
    send(CMD_GLOBAL);
    send(8'h01);
    chk("glb_we", we_bus(), W_GLB);
    chk("glb_stop", stop_o, 1);
    chk("glb_err", err_o, 0);

`ifdef CMD_TIMEOUT_EN
    // Stalled period command aborts after the idle limit.
    @(negedge clk_i);
    send(CMD_PERIOD);
    send(8'h14);
    pulses = 0;
    begin
      int waited;
      waited = 0;
      while (!err_o && waited < 150) begin
        if (we_bus() != 0) pulses++;
        @(negedge clk_i);
        waited++;
      end
      chk("tmo_err_seen", err_o, 1);
      chk("tmo_window", (waited >= 95 && waited <= 105), 1);
    end
    chk("tmo_busy", busy_o, 0);
    chk("tmo_no_strobe", {pulses[7:0], we_bus()}, '0);
    chk("tmo_period_kept", {slow_period_o, fast_period_o}, {8'h00, 8'h00});
    send(8'h05);
    chk("tmo_follow_err", err_o, 1);
    chk("tmo_follow_busy", busy_o, 0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
